// File: rtl/tdm_mux8.sv
// tdm_mux8: 8-to-1 time-division multiplexer / serializer.
// Snapshots an 8-bit frame and plays one channel per slot onto out.
module tdm_mux8 #(
    parameter int SLOT_CYCLES = 1,
    parameter int CW          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    input  logic d_valid,
    output logic d_ready,
    output logic out,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic out_valid,
    output logic frame_start
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CW-1:0] DW_MAX = CW'(SLOT_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    shadow;
    logic [7:0]    shadow_nx;
    logic [2:0]    slot;
    logic [2:0]    slot_nx;
    logic [CW-1:0] dwell;
    logic [CW-1:0] dwell_nx;
    logic          armed;
    logic          last;
    logic          load;
    logic          out_nx;
    logic          fs_nx;
    logic [7:0]    frame;

    assign frame = {d7, d6, d5, d4, d3, d2, d1, d0};

    // armed keeps d_ready low until the first edge after reset release
    assign last    = (state == SEND) && (slot == 3'd7) && (dwell == DW_MAX);
    assign d_ready = armed && ((state == IDLE) || last);
    assign load    = d_valid && d_ready;

    always_comb begin
        state_nx  = state;
        shadow_nx = shadow;
        slot_nx   = slot;
        dwell_nx  = dwell;
        unique case (state)
            IDLE: begin
                if (load) begin
                    shadow_nx = frame;
                    slot_nx   = 3'd0;
                    dwell_nx  = '0;
                    state_nx  = SEND;
                end
            end
            SEND: begin
                if (last) begin
                    slot_nx  = 3'd0;
                    dwell_nx = '0;
                    if (load) begin
                        shadow_nx = frame;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (dwell == DW_MAX) begin
                    dwell_nx = '0;
                    slot_nx  = slot + 3'd1;
                end else begin
                    dwell_nx = dwell + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        out_nx = (state_nx == SEND) && shadow_nx[slot_nx];
        fs_nx  = (state_nx == SEND) && (slot_nx == 3'd0)
                 && (dwell_nx == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shadow      <= 8'h00;
            slot        <= 3'd0;
            dwell       <= '0;
            armed       <= 1'b0;
            out         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            shadow      <= shadow_nx;
            slot        <= slot_nx;
            dwell       <= dwell_nx;
            armed       <= 1'b1;
            out         <= out_nx;
            frame_start <= fs_nx;
        end
    end

    assign {s2, s1, s0} = slot;
    assign out_valid    = (state == SEND);

endmodule

// File: doc/tdm_mux8.md
Name: tdm_mux8

Overview:
- 8-to-1 time-division multiplexer and serializer. It is the transmit end for the team's 1-to-8 Demultiplexer.
- Accepts an 8-bit frame (one bit per channel, d0..d7) through a valid/ready handshake. Snapshots the frame, then drives one channel per slot onto serial line `out`, with slot index on s2,s1,s0.
- A downstream Demultiplexer wired to out/s0/s1/s2 reproduces each channel on the matching d-output during that channel's slot.

Parameters:
- SLOT_CYCLES, 1, clock cycles each slot is held (legal range 1..256).
- CW, 8, width of internal dwell counter; must satisfy 2^CW >= SLOT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- d0..d7  input  1 each  channel data bits, sampled only on handshake.
- d_valid  input  1  frame on d0..d7 is valid.
- d_ready  output  1  block can accept a frame this cycle.
- out  output  1  serial data for current slot.
- s0,s1,s2  output  1 each  slot index of current slot; s2 is MSB.
- out_valid  output  1  out/s* carry a live slot.
- frame_start  output  1  one-cycle pulse on first cycle of slot 0.

Behaviour:
- **Reset.** rst=1 forces state IDLE, shadow=8'h00, slot=0 and dwell=0 immediately, regardless of clk. While reset is asserted: out=0, s2..s0=0, out_valid=0, frame_start=0, d_ready=0. d_ready rises on the first clk edge after rst deasserts.
- **Reset mid-frame.** The frame in progress is aborted. No remaining slots are emitted.
- **States.** Two states: IDLE and SEND.
- **IDLE:**
  - d_ready=1, out_valid=0, out=0, s*=0.
  - On an edge with d_valid=1, d_ready=1: shadow<=d0..d7 (bit i = di), slot<=0, dwell<=0, state->SEND.
- **SEND:**
  - Outputs are registered: out=shadow[slot], {s2,s1,s0}=slot, out_valid=1.
  - frame_start=1 only when slot=0 and dwell=0.
  - Each edge: if dwell<SLOT_CYCLES-1, dwell++. Otherwise dwell<=0 and slot++.
- **Latency.** Frame is accepted at edge N. Slot 0 is visible after edge N. A frame occupies exactly 8*SLOT_CYCLES cycles.
- **Last cycle of a frame** (slot=7, dwell=SLOT_CYCLES-1):
  - d_ready=1 in this cycle; it is 0 in every other SEND cycle.
  - If d_valid=1 on that edge, the new frame loads, slot wraps to 0 and the state stays SEND. Slot 0 of the new frame follows slot 7 with zero gap cycles, and frame_start pulses again.
  - If d_valid=0 on that edge, state->IDLE. out_valid=0 from the next cycle.
- **Input stability.** d0..d7 changing during SEND has no effect on out; only the shadow register drives out.
- **Unsupported handshake.** d_valid asserted while d_ready=0 is not consumed. The source must hold d_valid and data until it sees d_ready=1.
- **SLOT_CYCLES=1.** The dwell counter is degenerate; slot advances every edge. Implement so dwell compare is against 0.
- **Slot counter.** 3 bits, wraps 7->0 only on frame reload. It never free-runs in IDLE.
- **Glitch-free outputs.** All outputs except d_ready are flop outputs.
  - d_ready is combinational from state/slot/dwell only. It has no path from d_valid.

Test Plan:
- **Reset mid-frame.** Assert rst with slot=3. Required: out_valid, out, s2..s0 and frame_start all read 0 before the next clk edge. After release, d_ready=1 one edge later and no slots resume.
- **Single frame, SLOT_CYCLES=1.** After reset, present d7..d0=8'b1010_0110 with d_valid=1 for one cycle. Required:
  - out_valid=1 for exactly 8 cycles starting the next cycle.
  - {s2,s1,s0} steps 0..7; out sequence is 0,1,1,0,0,1,0,1.
  - frame_start is high only in the slot-0 cycle, then the block returns to IDLE.
- **Back-to-back frames.** Frame A=8'hFF, then hold d_valid=1 with B=8'h00. Required:
  - B is accepted on the slot-7 edge of A.
  - 16 consecutive out_valid cycles with out 1×8 then 0×8.
  - Two frame_start pulses 8 cycles apart.
  - d_ready is high only in IDLE and in each slot-7 cycle.
- **Dwell, SLOT_CYCLES=3.** Frame 8'h81. Required:
  - Each slot is held 3 cycles; 24 cycles total.
  - out=1 during slots 0 and 7 only.
  - frame_start is 1 for exactly 1 cycle.
- **Input stability and held-off handshake.** Toggle d0..d7 every cycle during SEND. Required: out matches the captured frame. Also raise d_valid at slot=2 with new data. Required: it is not accepted until the slot-7 edge, and that data is what frame 2 carries.
- **Loopback.** Connect out/s0/s1/s2 to a Demultiplexer with a per-output capture flop enabled by out_valid. Send 8'h5A. Required: after 8 cycles the captured d7..d0 equals 8'h5A.
